// File: rtl/fp_normalize_pipe_if.sv
// Handshake/data bundle for fp_normalize_pipe: CLA-side input channel and rounder-side output channel.
// The master drives operations in and accepts results; the slave is the normaliser.
interface fp_normalize_pipe_if #(
    parameter int MW    = 24,
    parameter int EW    = 8,
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [MW+2:0]    in_lane;
    logic             in_add_sub;
    logic             in_carry;
    logic [EW:0]      in_exp;
    logic             in_sticky;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [MW-1:0]    out_mant;
    logic             out_g;
    logic             out_r;
    logic             out_sticky;
    logic [EW:0]      out_exp;
    logic             out_zero;
    logic             out_denorm;
    logic             out_ovf;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_lane, in_add_sub, in_carry, in_exp, in_sticky, in_tag, out_ready,
        input  in_ready, out_valid, out_mant, out_g, out_r, out_sticky, out_exp,
               out_zero, out_denorm, out_ovf, out_tag
    );

    modport slave (
        input  in_valid, in_lane, in_add_sub, in_carry, in_exp, in_sticky, in_tag, out_ready,
        output in_ready, out_valid, out_mant, out_g, out_r, out_sticky, out_exp,
               out_zero, out_denorm, out_ovf, out_tag
    );
endinterface

// File: rtl/fp_normalize_pipe.sv
// Two-stage post-adder normaliser: stage 1 does zero detect, LZC, shift clamp and the add path;
// stage 2 does the left shift, exponent subtraction and flags, and drives all outputs from registers.
module fp_normalize_pipe #(
    parameter int MW    = 24,
    parameter int EW    = 8,
    parameter int TAG_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    fp_normalize_pipe_if.slave bus
);
    localparam int LZW = $clog2(MW + 3);
    localparam int CW  = (LZW > EW + 1) ? LZW : EW + 1;
    localparam logic [EW+1:0] OVF_LIM = {2'b00, {EW{1'b1}}};

    typedef struct packed {
        logic             zero;
        logic             sub;
        logic [MW+1:0]    lane;
        logic [LZW-1:0]   shamt;
        logic [EW:0]      exp;
        logic             ovf;
        logic [MW-1:0]    mant;
        logic             g;
        logic             r;
        logic             sticky;
        logic [TAG_W-1:0] tag;
    } s1_t;

    typedef struct packed {
        logic [MW-1:0]    mant;
        logic             g;
        logic             r;
        logic             sticky;
        logic [EW:0]      exp;
        logic             zero;
        logic             denorm;
        logic             ovf;
        logic [TAG_W-1:0] tag;
    } out_t;

    function automatic logic [LZW-1:0] lzc_f(input logic [MW+1:0] v);
        logic [LZW-1:0] n;
        logic           hit;
        n   = '0;
        hit = 1'b0;
        for (int i = MW + 1; i >= 0; i--) begin
            if (!hit && v[i]) begin
                hit = 1'b1;
            end else if (!hit) begin
                n = n + LZW'(1'b1);
            end else begin
                hit = 1'b1;
            end
        end
        return (n > LZW'(MW + 1)) ? LZW'(MW + 1) : n;
    endfunction

    logic           s1_valid_q;
    logic           out_valid_q;
    s1_t            s1_d;
    s1_t            s1_q;
    out_t           out_d;
    out_t           out_q;
    logic           s2_adv_s;
    logic           s1_adv_s;
    logic [LZW-1:0] lzc_s;
    logic [CW-1:0]  lzc_cw_s;
    logic [CW-1:0]  exp_cw_s;
    logic [CW-1:0]  shamt_cw_s;
    logic [CW-1:0]  sub_exp_cw_s;
    logic [EW+1:0]  add_exp_w_s;
    logic [MW+1:0]  shifted_s;

    // A stage may load when it is empty or its current contents move on this cycle.
    assign s2_adv_s     = !out_valid_q || bus.out_ready;
    assign s1_adv_s     = !s1_valid_q || s2_adv_s;
    assign bus.in_ready = s1_adv_s;

    // Stage 1 next state: zero detect, clamped shift amount and the complete add-path result.
    always_comb begin
        s1_d        = '0;
        lzc_s       = lzc_f(bus.in_lane[MW+1:0]);
        lzc_cw_s    = CW'(lzc_s);
        exp_cw_s    = CW'(bus.in_exp);
        add_exp_w_s = {1'b0, bus.in_exp} + {{(EW + 1){1'b0}}, bus.in_carry};
        // Never shift the exponent below 1; what remains unnormalised becomes subnormal.
        if (bus.in_exp == '0) begin
            shamt_cw_s = '0;
        end else if (lzc_cw_s < exp_cw_s - CW'(1'b1)) begin
            shamt_cw_s = lzc_cw_s;
        end else begin
            shamt_cw_s = exp_cw_s - CW'(1'b1);
        end
        s1_d.zero  = (bus.in_lane == '0);
        s1_d.sub   = bus.in_add_sub;
        s1_d.lane  = bus.in_lane[MW+1:0];
        s1_d.shamt = shamt_cw_s[LZW-1:0];
        s1_d.tag   = bus.in_tag;
        s1_d.ovf   = !bus.in_add_sub && !s1_d.zero && (add_exp_w_s >= OVF_LIM);
        if (bus.in_add_sub) begin
            s1_d.exp    = bus.in_exp;
            s1_d.sticky = bus.in_sticky;
        end else if (bus.in_carry) begin
            s1_d.mant   = bus.in_lane[MW+2:3];
            s1_d.g      = bus.in_lane[2];
            s1_d.r      = bus.in_lane[1];
            s1_d.sticky = bus.in_sticky | bus.in_lane[0];
            s1_d.exp    = add_exp_w_s[EW:0];
        end else begin
            s1_d.mant   = bus.in_lane[MW+1:2];
            s1_d.g      = bus.in_lane[1];
            s1_d.r      = bus.in_lane[0];
            s1_d.sticky = bus.in_sticky;
            s1_d.exp    = bus.in_exp;
        end
    end

    // Stage 2 next state: apply the cancellation shift and pick the result for this path.
    always_comb begin
        shifted_s    = s1_q.lane << s1_q.shamt;
        sub_exp_cw_s = CW'(s1_q.exp) - CW'(s1_q.shamt);
        out_d        = '0;
        out_d.sticky = s1_q.sticky;
        out_d.tag    = s1_q.tag;
        if (s1_q.zero) begin
            out_d.zero = 1'b1;
        end else if (s1_q.sub) begin
            out_d.mant = shifted_s[MW+1:2];
            out_d.g    = shifted_s[1];
            out_d.r    = shifted_s[0];
            if (shifted_s[MW+1]) begin
                out_d.exp = sub_exp_cw_s[EW:0];
            end else begin
                out_d.denorm = 1'b1;
                out_d.exp    = '0;
            end
        end else begin
            out_d.mant = s1_q.mant;
            out_d.g    = s1_q.g;
            out_d.r    = s1_q.r;
            out_d.exp  = s1_q.exp;
            out_d.ovf  = s1_q.ovf;
        end
    end

    // Stage 1 register.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_q       <= '0;
        end else if (s1_adv_s) begin
            s1_valid_q <= bus.in_valid;
            s1_q       <= s1_d;
        end
    end

    // Stage 2 / output register; holds while the rounder stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else if (s2_adv_s) begin
            out_valid_q <= s1_valid_q;
            out_q       <= out_d;
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_mant   = out_q.mant;
    assign bus.out_g      = out_q.g;
    assign bus.out_r      = out_q.r;
    assign bus.out_sticky = out_q.sticky;
    assign bus.out_exp    = out_q.exp;
    assign bus.out_zero   = out_q.zero;
    assign bus.out_denorm = out_q.denorm;
    assign bus.out_ovf    = out_q.ovf;
    assign bus.out_tag    = out_q.tag;
endmodule

// File: tb/tb_fp_normalize_pipe.sv
// Self-checking bench for fp_normalize_pipe: directed vectors, backpressure, random traffic
// against a scoreboard fed by an arithmetic reference model, and reset in mid-stream.
module tb_fp_normalize_pipe;
    localparam int MW    = 24;
    localparam int EW    = 8;
    localparam int TAG_W = 4;
    localparam int L     = MW + 3;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [MW-1:0]    mant;
        logic             g;
        logic             r;
        logic             sticky;
        logic [EW:0]      exp;
        logic             zero;
        logic             denorm;
        logic             ovf;
    } res_t;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;
    res_t exp_q[$];

    fp_normalize_pipe_if #(.MW(MW), .EW(EW), .TAG_W(TAG_W)) bus ();

    fp_normalize_pipe #(.MW(MW), .EW(EW), .TAG_W(TAG_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic res_t mk(input logic [TAG_W-1:0] tg, input logic [MW-1:0] m, input logic g,
                                input logic r, input logic st, input logic [EW:0] e,
                                input logic z, input logic dn, input logic ov);
        res_t o;
        o.tag = tg; o.mant = m; o.g = g; o.r = r; o.sticky = st;
        o.exp = e; o.zero = z; o.denorm = dn; o.ovf = ov;
        return o;
    endfunction

    // Reference: normalise by counting zeros and shifting with integer arithmetic.
    function automatic res_t model(input logic [L-1:0] lane, input logic sub, input logic carry,
                                   input logic [EW:0] e, input logic st, input logic [TAG_W-1:0] tg);
        res_t          o;
        int            ex;
        int            lz;
        int            sh;
        logic [MW+1:0] low;
        o     = '0;
        o.tag = tg;
        o.sticky = st;
        ex    = 0;
        if (lane == '0) begin
            o.zero = 1'b1;
        end else if (!sub) begin
            if (carry) begin
                o.mant = lane[MW+2:3]; o.g = lane[2]; o.r = lane[1];
                o.sticky = st | lane[0];
                ex = int'(e) + 1;
            end else begin
                o.mant = lane[MW+1:2]; o.g = lane[1]; o.r = lane[0];
                ex = int'(e);
            end
            o.ovf = (ex >= (1 << EW) - 1);
        end else begin
            lz = 0;
            while (lz < MW + 1 && lane[MW+1-lz] == 1'b0) lz++;
            sh  = (e == '0) ? 0 : ((lz < int'(e) - 1) ? lz : int'(e) - 1);
            low = lane[MW+1:0] << sh;
            o.mant = low[MW+1:2]; o.g = low[1]; o.r = low[0];
            ex = int'(e) - sh;
            if (!low[MW+1]) begin
                o.denorm = 1'b1;
                ex = 0;
            end
        end
        o.exp = ex[EW:0];
        return o;
    endfunction

    function automatic res_t obs_f();
        return mk(bus.out_tag, bus.out_mant, bus.out_g, bus.out_r, bus.out_sticky, bus.out_exp,
                  bus.out_zero, bus.out_denorm, bus.out_ovf);
    endfunction

    task automatic set_in(input logic [L-1:0] lane, input logic sub, input logic carry,
                          input logic [EW:0] e, input logic st, input logic [TAG_W-1:0] tg);
        bus.in_lane = lane; bus.in_add_sub = sub; bus.in_carry = carry;
        bus.in_exp = e; bus.in_sticky = st; bus.in_tag = tg;
    endtask

    task automatic rand_inputs();
        logic [63:0]   v;
        logic [L-1:0]  lane;
        logic          sub;
        logic [EW:0]   e;
        v    = {$urandom, $urandom};
        lane = v[L-1:0] >> $urandom_range(0, L);
        sub  = 1'($urandom_range(0, 1));
        if (sub) lane[MW+2] = 1'b0;
        case ($urandom_range(0, 2))
            0:       e = (EW + 1)'($urandom_range(0, 30));
            1:       e = (EW + 1)'($urandom_range(250, 256));
            default: e = (EW + 1)'($urandom_range(0, 511));
        endcase
        set_in(lane, sub, 1'($urandom_range(0, 1)), e, 1'($urandom_range(0, 1)),
               TAG_W'($urandom_range(0, 15)));
    endtask

    // Called just after a falling edge with inputs settled: score the transfers of the coming edge.
    task automatic step();
        res_t e;
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_out", 64'(bus.out_valid), 64'd0);
            end else begin
                e = exp_q.pop_front();
                check_eq("result", 64'(obs_f()), 64'(e));
            end
        end
        if (!rst && bus.in_valid && bus.in_ready)
            exp_q.push_back(model(bus.in_lane, bus.in_add_sub, bus.in_carry, bus.in_exp,
                                  bus.in_sticky, bus.in_tag));
        @(negedge clk);
    endtask

    task automatic directed(input string name, input logic [L-1:0] lane, input logic sub,
                            input logic carry, input logic [EW:0] e, input logic st,
                            input logic [TAG_W-1:0] tg, input res_t want);
        int lat;
        set_in(lane, sub, carry, e, st, tg);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        step();
        bus.in_valid = 1'b0;
        lat = 1;
        #1;
        while (!bus.out_valid && lat < 8) begin
            @(negedge clk);
            #1;
            lat++;
        end
        check_eq({name, "_latency"}, 64'(lat), 64'd2);
        check_eq(name, 64'(obs_f()), 64'(want));
        step();
    endtask

    initial begin
        int          tag_n;
        int          got;
        logic        seen_low;
        logic        have_snap;
        res_t        snap;
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        set_in('0, 1'b0, 1'b0, '0, 1'b0, '0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("reset_out_valid", 64'(bus.out_valid), 64'd0);
        check_eq("reset_in_ready", 64'(bus.in_ready), 64'd1);
        check_eq("reset_outputs", 64'(obs_f()), 64'd0);

        directed("add_carry", 27'h4000001, 1'b0, 1'b1, 9'd127, 1'b0, 4'd1,
                 mk(4'd1, 24'h800000, 1'b0, 1'b0, 1'b1, 9'd128, 1'b0, 1'b0, 1'b0));
        directed("cancel", 27'h0000100, 1'b1, 1'b0, 9'd100, 1'b0, 4'd2,
                 mk(4'd2, 24'h800000, 1'b0, 1'b0, 1'b0, 9'd83, 1'b0, 1'b0, 1'b0));
        directed("subnormal", 27'h0000100, 1'b1, 1'b0, 9'd10, 1'b0, 4'd3,
                 mk(4'd3, 24'h008000, 1'b0, 1'b0, 1'b0, 9'd0, 1'b0, 1'b1, 1'b0));
        directed("zero", 27'h0000000, 1'b1, 1'b0, 9'd50, 1'b1, 4'd4,
                 mk(4'd4, 24'h000000, 1'b0, 1'b0, 1'b1, 9'd0, 1'b1, 1'b0, 1'b0));
        directed("overflow", 27'h4000000, 1'b0, 1'b1, 9'd254, 1'b0, 4'd5,
                 mk(4'd5, 24'h800000, 1'b0, 1'b0, 1'b0, 9'd255, 1'b0, 1'b0, 1'b1));

        // Backpressure: four back-to-back ops, rounder stalled for the first cycles.
        tag_n = 1; got = 0; seen_low = 1'b0; have_snap = 1'b0; snap = '0;
        for (int cyc = 0; cyc < 30 && got < 4; cyc++) begin
            bus.out_ready = (cyc >= 5);
            bus.in_valid  = (tag_n <= 4);
            rand_inputs();
            bus.in_tag = TAG_W'(tag_n);
            #1;
            if (!bus.in_ready) seen_low = 1'b1;
            if (bus.out_valid && !bus.out_ready) begin
                if (have_snap) check_eq("stall_hold", 64'(obs_f()), 64'(snap));
                snap      = obs_f();
                have_snap = 1'b1;
            end
            if (got > 0) check_eq("bp_no_gap", 64'(bus.out_valid), 64'd1);
            if (bus.out_valid && bus.out_ready) begin
                got++;
                check_eq("bp_order", 64'(bus.out_tag), 64'(got));
            end
            if (bus.in_valid && bus.in_ready) tag_n++;
            step();
        end
        bus.in_valid = 1'b0;
        check_eq("bp_in_ready_fell", 64'(seen_low), 64'd1);
        check_eq("bp_count", 64'(got), 64'd4);

        for (int c = 0; c < 800; c++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 9) < 7);
            rand_inputs();
            #1;
            step();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 10 && exp_q.size() > 0; c++) begin
            #1;
            step();
        end
        check_eq("drain_empty", 64'(exp_q.size()), 64'd0);

        // Reset with both stages full; stale results must never emerge.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.in_valid = 1'b1;
            rand_inputs();
            #1;
            step();
        end
        rst = 1'b1;
        rand_inputs();
        #1;
        step();
        rst           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        exp_q.delete();
        #1;
        check_eq("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        check_eq("midrst_in_ready", 64'(bus.in_ready), 64'd1);
        check_eq("midrst_outputs", 64'(obs_f()), 64'd0);
        for (int c = 0; c < 5; c++) begin
            check_eq("midrst_no_stale", 64'(bus.out_valid), 64'd0);
            step();
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
